// File: rtl/svga_timing_pkg.sv
// svga_timing_pkg: 800x600@60 timing constants, coordinate widths and receiver FSM states.
// Shared with the video output stage so both ends agree on the nominal raster.
package svga_timing_pkg;
  localparam int H_VISIBLE    = 800;
  localparam int H_SYNC_START = 840;
  localparam int H_SYNC_END   = 968;
  localparam int H_TOTAL      = 1056;
  localparam int V_VISIBLE    = 600;
  localparam int V_SYNC_START = 601;
  localparam int V_SYNC_END   = 605;
  localparam int V_TOTAL      = 628;
  localparam int XW = 11;
  localparam int YW = 10;
  typedef enum logic [1:0] {HUNT, LINE_LOCK, FRAME_LOCK} state_t;
endpackage

// File: rtl/svga_sync_receiver_if.sv
// svga_sync_receiver_if: video link inputs and reconstructed pixel outputs of the sync receiver.
//   hsync_i/vsync_i/color_i : link from the video output stage
//   x_o/y_o/color_o/pixel_valid_o/line_start_o/frame_start_o/h_err_o/v_err_o/locked_o : receiver results
//   master drives the link and observes results; slave is the receiver.
interface svga_sync_receiver_if;
  import svga_timing_pkg::*;
  logic          hsync_i;
  logic          vsync_i;
  logic [7:0]    color_i;
  logic [XW-1:0] x_o;
  logic [YW-1:0] y_o;
  logic [7:0]    color_o;
  logic          pixel_valid_o;
  logic          line_start_o;
  logic          frame_start_o;
  logic          h_err_o;
  logic          v_err_o;
  logic          locked_o;
  modport master (
    output hsync_i, vsync_i, color_i,
    input  x_o, y_o, color_o, pixel_valid_o, line_start_o, frame_start_o, h_err_o, v_err_o, locked_o
  );
  modport slave (
    input  hsync_i, vsync_i, color_i,
    output x_o, y_o, color_o, pixel_valid_o, line_start_o, frame_start_o, h_err_o, v_err_o, locked_o
  );
endinterface

// File: rtl/svga_sync_edge.sv
// svga_sync_edge: registers one sync input and flags its rising/falling edge.
//   clk_i, rst_i : clock, async active-high reset
//   d_i          : raw sync input
//   rise_o/fall_o: edge of the registered sample against the previous sample
module svga_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic s_q, p_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      s_q <= 1'b0;
      p_q <= 1'b0;
    end else begin
      s_q <= d_i;
      p_q <= s_q;
    end
  assign rise_o = s_q & ~p_q;
  assign fall_o = ~s_q & p_q;
endmodule

// File: rtl/svga_sync_receiver.sv
// svga_sync_receiver: locks onto SVGA syncs, rebuilds pixel coordinates and checks line/frame timing.
//   clk_i, rst_i : pixel clock, async active-high reset
//   bus (slave)  : sync/colour in; x/y, gated colour, valid, line/frame strobes, error pulses, lock out
// Two-stage pipeline: stage 1 registers the inputs, stage 2 registers every output.
module svga_sync_receiver
  import svga_timing_pkg::*;
#(
  parameter int H_VIS       = H_VISIBLE,
  parameter int H_SS        = H_SYNC_START,
  parameter int H_SE        = H_SYNC_END,
  parameter int H_TOT       = H_TOTAL,
  parameter int V_VIS       = V_VISIBLE,
  parameter int V_SS        = V_SYNC_START,
  parameter int V_SE        = V_SYNC_END,
  parameter int V_TOT       = V_TOTAL,
  parameter int LOCK_FRAMES = 2
) (
  input logic                clk_i,
  input logic                rst_i,
  svga_sync_receiver_if.slave bus
);
  logic hs_r, hs_f, vs_r, vs_f;
  logic [7:0] col_q, col_o_q;
  state_t st_q, st_d;
  logic [XW-1:0] x_q, x_n, x_d;
  logic [YW-1:0] y_q, y_n, y_d;
  logic [3:0] cnt_q, cnt_d;
  logic hunt, frame, at_hs, at_he, at_vs, at_ve, stray, h_err, v_err, v_lock, pv, ls, fs;
  logic pv_q, ls_q, fs_q, he_q, ve_q, lk_q;
  svga_sync_edge u_hs (.clk_i(clk_i), .rst_i(rst_i), .d_i(bus.hsync_i), .rise_o(hs_r), .fall_o(hs_f));
  svga_sync_edge u_vs (.clk_i(clk_i), .rst_i(rst_i), .d_i(bus.vsync_i), .rise_o(vs_r), .fall_o(vs_f));
  // x_q/y_q hold the coordinate of the sample now at the outputs; x_n/y_n predict the stage-1 sample.
  always_comb begin
    hunt   = st_q == HUNT;
    frame  = st_q == FRAME_LOCK;
    x_n    = (x_q == XW'(H_TOT - 1)) ? '0 : x_q + 1'b1;
    y_n    = (x_q != XW'(H_TOT - 1)) ? y_q : (y_q == YW'(V_TOT - 1)) ? '0 : y_q + 1'b1;
    at_hs  = x_n == XW'(H_SS);
    at_he  = x_n == XW'(H_SE);
    at_vs  = x_n == '0 && y_n == YW'(V_SS);
    at_ve  = x_n == '0 && y_n == YW'(V_SE);
    // An early/late HSYNC rise is still a usable line reference, so it reloads x instead of hunting.
    stray  = !hunt && hs_r && !at_hs;
    h_err  = !hunt && ((hs_r != at_hs) || (hs_f != at_he));
    v_lock = st_q == LINE_LOCK && vs_r && x_n == '0;
    v_err  = frame ? ((vs_r != at_vs) || (vs_f != at_ve)) : (st_q == LINE_LOCK && vs_r && x_n != '0);
    x_d    = hunt ? (hs_r ? XW'(H_SS) : '0) : stray ? XW'(H_SS) : x_n;
    y_d    = hunt ? '0 : v_lock ? YW'(V_SS) : y_n;
    st_d   = hunt ? (hs_r ? LINE_LOCK : HUNT) : stray ? LINE_LOCK : h_err ? HUNT :
             v_err ? LINE_LOCK : v_lock ? FRAME_LOCK : st_q;
    cnt_d  = (h_err || v_err) ? '0 :
             (frame && x_n == '0 && y_n == '0 && cnt_q != 4'hf) ? cnt_q + 1'b1 : cnt_q;
    pv     = frame && x_d < XW'(H_VIS) && y_d < YW'(V_VIS);
    ls     = !hunt && x_d == '0;
    fs     = frame && x_d == '0 && y_d == '0;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      st_q    <= HUNT;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      col_q   <= '0;
      col_o_q <= '0;
      pv_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      he_q    <= 1'b0;
      ve_q    <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      col_q   <= bus.color_i;
      col_o_q <= pv ? col_q : '0;
      pv_q    <= pv;
      ls_q    <= ls;
      fs_q    <= fs;
      he_q    <= h_err;
      ve_q    <= v_err;
      lk_q    <= cnt_d >= 4'(LOCK_FRAMES);
    end
  assign bus.x_o           = x_q;
  assign bus.y_o           = y_q;
  assign bus.color_o       = col_o_q;
  assign bus.pixel_valid_o = pv_q;
  assign bus.line_start_o  = ls_q;
  assign bus.frame_start_o = fs_q;
  assign bus.h_err_o       = he_q;
  assign bus.v_err_o       = ve_q;
  assign bus.locked_o      = lk_q;
endmodule
